// File: rtl/shift_register_sipo_32bit.sv
// Serial-in, parallel-out shift register: one bit captured per clock, last WIDTH bits shown in parallel.
// Latency: a bit is at the entry position one edge after sampling and drops out WIDTH edges after sampling.
// Backpressure: none; every clock edge out of reset captures a bit, and the consumer must keep up.
// Optional build macro SIPO_WORD_STROBE_EN adds word_valid/bit_count word framing outputs.
module shift_register_sipo_32bit #(
  parameter int WIDTH     = 32,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             serial_in,
  output logic [WIDTH-1:0] parallel_out
`ifdef SIPO_WORD_STROBE_EN
  ,
  output logic                     word_valid,
  output logic [$clog2(WIDTH)-1:0] bit_count
`endif
);

  // Shift one bit in on every edge; the entry end depends on MSB_FIRST, and the oldest bit falls off the far end.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      parallel_out <= '0;
    end else if (MSB_FIRST) begin
      parallel_out <= {serial_in, parallel_out[WIDTH-1:1]};
    end else begin
      parallel_out <= {parallel_out[WIDTH-2:0], serial_in};
    end
  end

`ifdef SIPO_WORD_STROBE_EN
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  // Count the captures within a word and pulse word_valid for the cycle after the WIDTH-th capture,
  // which is exactly when parallel_out holds the complete word.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bit_count  <= '0;
      word_valid <= 1'b0;
    end else if (bit_count == LAST_BIT) begin
      bit_count  <= '0;
      word_valid <= 1'b1;
    end else begin
      bit_count  <= bit_count + CW'(1);
      word_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_shift_register_sipo_32bit.sv
module tb_shift_register_sipo_32bit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        serial_in = 1'b1;
  logic [31:0] p_lsb;
  logic [31:0] p_msb;
`ifdef SIPO_WORD_STROBE_EN
  logic        wv_lsb, wv_msb;
  logic [4:0]  bc_lsb, bc_msb;
  int          pulses = 0;
`endif

  int total = 0;
  int passed = 0;

  shift_register_sipo_32bit #(.WIDTH(32), .MSB_FIRST(1'b0)) dut_lsb (
    .clock(clock), .reset(reset), .serial_in(serial_in), .parallel_out(p_lsb)
`ifdef SIPO_WORD_STROBE_EN
    , .word_valid(wv_lsb), .bit_count(bc_lsb)
`endif
  );

  shift_register_sipo_32bit #(.WIDTH(32), .MSB_FIRST(1'b1)) dut_msb (
    .clock(clock), .reset(reset), .serial_in(serial_in), .parallel_out(p_msb)
`ifdef SIPO_WORD_STROBE_EN
    , .word_valid(wv_msb), .bit_count(bc_msb)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] p0;
    logic [31:0] p1;
    logic        wv;
    logic [4:0]  bc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m0 = '0;
  logic [31:0] m1 = '0;
  logic [4:0]  mcnt = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m0 = '0;
    m1 = '0;
    mcnt = '0;
  endtask

  // Drive one bit just after an edge, queue the expected result, compare after the capture edge.
  task automatic drive_bit(input logic b);
    exp_t e;
    serial_in = b;
    m0 = {m0[30:0], b};
    m1 = {b, m1[31:1]};
    e.p0 = m0;
    e.p1 = m1;
    e.wv = (mcnt == 5'd31);
    mcnt = mcnt + 5'd1;
    e.bc = mcnt;
    sb.push_back(e);
    @(posedge clock);
    #1;
    e = sb.pop_front();
    check("lsb_first_word", p_lsb, e.p0);
    check("msb_first_word", p_msb, e.p1);
`ifdef SIPO_WORD_STROBE_EN
    check("word_valid", {31'd0, wv_lsb}, {31'd0, e.wv});
    check("bit_count", {27'd0, bc_lsb}, {27'd0, e.bc});
    check("word_valid_msb", {31'd0, wv_msb}, {31'd0, e.wv});
    if (wv_lsb === 1'b1) pulses++;
`endif
  endtask

  task automatic release_reset();
    @(posedge clock);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [6:0] pat;
    pat = 7'b0010010;

    // Held in reset with serial_in=1 and the clock running: outputs stay clear.
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      check("reset_hold_lsb", p_lsb, 32'h0);
      check("reset_hold_msb", p_msb, 32'h0);
`ifdef SIPO_WORD_STROBE_EN
      check("reset_hold_wv", {31'd0, wv_lsb}, 32'd0);
      check("reset_hold_bc", {27'd0, bc_lsb}, 32'd0);
`endif
    end

    release_reset();

    // Pattern 0,0,1,0,0,1,0 then zeros, walking the ones up to and past bit 31.
    for (int i = 6; i >= 0; i--) drive_bit(pat[i]);
    check("pattern_7", p_lsb, 32'h0000_0012);
    repeat (25) drive_bit(1'b0);
    check("pattern_32", p_lsb, 32'h2400_0000);
    drive_bit(1'b0);
    check("pattern_33", p_lsb, 32'h4800_0000);
    drive_bit(1'b0);
    check("pattern_34", p_lsb, 32'h9000_0000);
    check("pattern_34_bit31", {31'd0, p_lsb[31]}, 32'd1);

    // All ones, then a single zero.
    repeat (32) drive_bit(1'b1);
    check("all_ones", p_lsb, 32'hFFFF_FFFF);
    check("all_ones_msb", p_msb, 32'hFFFF_FFFF);
    drive_bit(1'b0);
    check("ones_then_zero", p_lsb, 32'hFFFF_FFFE);

    // Reset mid-stream clears without waiting for a clock edge.
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_lsb", p_lsb, 32'h0);
    check("async_reset_msb", p_msb, 32'h0);
    release_reset();

    // Partial word, then reset again: the counter must restart.
    repeat (10) drive_bit(1'($urandom_range(0, 1)));
    #2;
    reset = 1'b0;
    #1;
    check("mid_word_reset", p_lsb, 32'h0);
    release_reset();

    // MSB_FIRST=1: one then 31 zeros walks from bit 31 to bit 0.
`ifdef SIPO_WORD_STROBE_EN
    pulses = 0;
`endif
    drive_bit(1'b1);
    check("msb_first_edge1", p_msb, 32'h8000_0000);
    repeat (31) drive_bit(1'b0);
    check("msb_first_edge32", p_msb, 32'h0000_0001);
`ifdef SIPO_WORD_STROBE_EN
    check("pulses_after_reset", pulses, 1);
    pulses = 0;
`endif

    // 64 random bits: two complete words.
    repeat (64) drive_bit(1'($urandom_range(0, 1)));
`ifdef SIPO_WORD_STROBE_EN
    check("pulses_64_bits", pulses, 2);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
